// File: rtl/spi_pwm_reg_if_if.sv
// rtl/spi_pwm_reg_if_if.sv - SPI pin bundle between an external controller and spi_pwm_reg_if
`timescale 1ns/1ps

interface spi_pwm_reg_if_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
    modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_pwm_reg_if.sv
// rtl/spi_pwm_reg_if.sv - SPI mode-0 frame receiver driving the PWM register bank
// Optional readback on cipo is enabled by defining SPI_READBACK_EN.
`timescale 1ns/1ps

module spi_pwm_reg_if #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_pwm_reg_if_if.slave spi,
    output logic [7:0]      en_reg_out_7_0,
    output logic [7:0]      en_reg_out_15_8,
    output logic [7:0]      en_reg_pwm_7_0,
    output logic [7:0]      en_reg_pwm_15_8,
    output logic [7:0]      pwm_duty_cycle,
    output logic            frame_done
);

    localparam int         NUM_REGS   = 5;
    localparam logic [6:0] MAX_ADDR_W = 7'(MAX_ADDR);
    localparam logic [6:0] LAST_REG_W = 7'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL,
        ST_COMMIT
    } state_t;

    function automatic logic addr_ok(input logic [6:0] a);
        return (a <= MAX_ADDR_W) && (a <= LAST_REG_W);
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
    logic [SYNC_STAGES-1:0] ncs_valid_q, ncs_valid_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ncs_hist_q,  ncs_hist_d;
    logic                   armed_q,     armed_d;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  count_q, count_d;
    logic        ovf_q,   ovf_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  reg_q [NUM_REGS];
    logic [7:0]  reg_d [NUM_REGS];

    logic sclk_s, copi_s, ncs_s;
    logic sclk_rise, ncs_fall, ncs_rise;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0],  spi.ncs};
        ncs_valid_d = {ncs_valid_q[SYNC_STAGES-2:0], 1'b1};

        sclk_s = sclk_sync_q[SYNC_STAGES-1];
        copi_s = copi_sync_q[SYNC_STAGES-1];
        ncs_s  = ncs_sync_q[SYNC_STAGES-1];

        sclk_hist_d = sclk_s;
        ncs_hist_d  = ncs_s;

        sclk_rise = sclk_s & ~sclk_hist_q;
        ncs_fall  = ~ncs_s & ncs_hist_q;
        ncs_rise  = ncs_s & ~ncs_hist_q;

        // The synchroniser reset value of ncs is fake; only a high level that
        // actually came from the pin may arm frame reception.
        armed_d = armed_q | (ncs_valid_q[SYNC_STAGES-1] & ncs_s);
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        frame_done_d = 1'b0;
        reg_d        = reg_q;

        case (state_q)
            ST_IDLE: begin
                count_d = 5'd0;
                ovf_d   = 1'b0;
                if (ncs_fall && armed_q) begin
                    shift_d = 16'h0000;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s};
                    count_d = count_q + 5'd1;
                    if (count_q == 5'd15) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise) begin
                    ovf_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (!ovf_q && shift_q[15] && addr_ok(shift_q[14:8])) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (shift_q[14:8] == 7'(i)) begin
                            reg_d[i] = shift_q[7:0];
                        end
                    end
                    frame_done_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            copi_sync_q  <= '0;
            ncs_sync_q   <= '1;
            ncs_valid_q  <= '0;
            sclk_hist_q  <= 1'b0;
            ncs_hist_q   <= 1'b1;
            armed_q      <= 1'b0;
            state_q      <= ST_IDLE;
            shift_q      <= 16'h0000;
            count_q      <= 5'd0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= 8'h00;
            end
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            copi_sync_q  <= copi_sync_d;
            ncs_sync_q   <= ncs_sync_d;
            ncs_valid_q  <= ncs_valid_d;
            sclk_hist_q  <= sclk_hist_d;
            ncs_hist_q   <= ncs_hist_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_done_d;
            reg_q        <= reg_d;
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q, tx_d;
    logic       oe_q, oe_d;
    logic       sclk_fall;

    always_comb begin
        tx_d      = tx_q;
        oe_d      = oe_q;
        sclk_fall = ~sclk_s & sclk_hist_q;

        if (ncs_rise) begin
            oe_d = 1'b0;
        end else if (state_q == ST_SHIFT && count_q == 5'd7 && count_d == 5'd8) begin
            if (!shift_d[7]) begin
                tx_d = 8'h00;
                if (addr_ok(shift_d[6:0])) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (shift_d[6:0] == 7'(i)) begin
                            tx_d = reg_q[i];
                        end
                    end
                end
                oe_d = 1'b1;
            end
        // The falling edge right after the 8th rising edge keeps bit 7 on the
        // line so the controller samples it on the 9th rising edge.
        end else if (oe_q && sclk_fall && count_q > 5'd8) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q <= 8'h00;
            oe_q <= 1'b0;
        end else begin
            tx_q <= tx_d;
            oe_q <= oe_d;
        end
    end

    assign spi.cipo    = oe_q & tx_q[7];
    assign spi.cipo_oe = oe_q;
`else
    assign spi.cipo    = 1'b0;
    assign spi.cipo_oe = 1'b0;
`endif

    assign en_reg_out_7_0  = reg_q[0];
    assign en_reg_out_15_8 = reg_q[1];
    assign en_reg_pwm_7_0  = reg_q[2];
    assign en_reg_pwm_15_8 = reg_q[3];
    assign pwm_duty_cycle  = reg_q[4];
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_spi_pwm_reg_if.sv
// tb/tb_spi_pwm_reg_if.sv - scoreboard bench for spi_pwm_reg_if (readback checks when SPI_READBACK_EN is defined)
`timescale 1ns/1ps

module tb_spi_pwm_reg_if;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       frame_done;

    always #5 clk = ~clk;

    spi_pwm_reg_if_if spi_bus ();

    spi_pwm_reg_if #(
        .SYNC_STAGES(2),
        .MAX_ADDR   (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi            (spi_bus),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .frame_done     (frame_done)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [39:0] exp_q[$];
    logic [39:0] regs_vec;
    logic        cipo_smp [24];
    logic        oe_smp   [24];
    logic        oe_any;

    // {duty, pwm_15_8, pwm_7_0, out_15_8, out_7_0}
    assign regs_vec = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every frame_done cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL frame_done_unexpected: got regs 0x%010h with no write pending at %0t", regs_vec, $time);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if (regs_vec !== e) begin
                    miscompares++;
                    $display("FAIL commit_regs: got 0x%010h expected 0x%010h at %0t", regs_vec, e, $time);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] w, input int first, input int last);
        for (int i = first; i < last; i++) begin
            spi_bus.copi = (i < 16) ? w[15-i] : 1'b1;
            wait_cyc(8);
            cipo_smp[i] = spi_bus.cipo;
            oe_smp[i]   = spi_bus.cipo_oe;
            oe_any      = oe_any | spi_bus.cipo_oe;
            spi_bus.sclk = 1'b1;
            wait_cyc(8);
            spi_bus.sclk = 1'b0;
        end
        spi_bus.copi = 1'b0;
    endtask

    task automatic finish_frame(input string name, input logic [39:0] regs_after);
        wait_cyc(8);
        spi_bus.ncs = 1'b1;
        wait_cyc(12);
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check({name, "_regs"}, 64'(regs_vec), 64'(regs_after));
        check({name, "_oe_after"}, 64'(spi_bus.cipo_oe), 64'd0);
`ifndef SPI_READBACK_EN
        check({name, "_oe_never"}, 64'(oe_any), 64'd0);
`endif
    endtask

    task automatic frame(input string name, input logic [15:0] w, input int nbits,
                         input logic commit, input logic [39:0] regs_after);
        if (commit) exp_q.push_back(regs_after);
        oe_any = 1'b0;
        spi_bus.ncs = 1'b0;
        wait_cyc(8);
        send_bits(w, 0, nbits);
        finish_frame(name, regs_after);
    endtask

`ifdef SPI_READBACK_EN
    task automatic check_readback(input string name, input logic [7:0] exp_data);
        logic [7:0]  got;
        logic [15:0] oe_pat;
        for (int i = 0; i < 16; i++) oe_pat[i] = oe_smp[i];
        for (int i = 8; i < 16; i++) got[15-i] = cipo_smp[i];
        check({name, "_data"}, 64'(got), 64'(exp_data));
        check({name, "_oe_window"}, 64'(oe_pat), 64'h0000_0000_0000_FF00);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        spi_bus.ncs  = 1'b1;
        rst_n = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(1);
        check("reset_regs",       64'(regs_vec),         64'd0);
        check("reset_frame_done", 64'(frame_done),       64'd0);
        check("reset_cipo_oe",    64'(spi_bus.cipo_oe),  64'd0);
        check("reset_cipo",       64'(spi_bus.cipo),     64'd0);
        wait_cyc(6);

        frame("wr_out_lo",  16'h80F0, 16, 1'b1, 40'h00_00_00_00_F0);
        frame("wr_duty_55", 16'h8455, 16, 1'b1, 40'h55_00_00_00_F0);
        frame("wr_duty_80", 16'h8480, 16, 1'b1, 40'h80_00_00_00_F0);
        frame("addr5",      16'h8512, 16, 1'b0, 40'h80_00_00_00_F0);
        frame("read0",      16'h00AA, 16, 1'b0, 40'h80_00_00_00_F0);
        frame("trunc12",    16'h81FF, 12, 1'b0, 40'h80_00_00_00_F0);
        frame("ovf17",      16'h82C3, 17, 1'b0, 40'h80_00_00_00_F0);

        // Reset lands mid-frame; the rest of that frame must be ignored.
        oe_any = 1'b0;
        spi_bus.ncs = 1'b0;
        wait_cyc(8);
        send_bits(16'h8333, 0, 9);
        rst_n = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        send_bits(16'h8333, 9, 16);
        finish_frame("rst_mid", 40'h00_00_00_00_00);

        frame("wr_pwm_hi",  16'h8333, 16, 1'b1, 40'h00_33_00_00_00);
        frame("wr_out_hi",  16'h8101, 16, 1'b1, 40'h00_33_00_01_00);
        frame("wr_pwm_lo",  16'h82A5, 16, 1'b1, 40'h00_33_A5_01_00);
        frame("wr_out_ff",  16'h80FF, 16, 1'b1, 40'h00_33_A5_01_FF);
        frame("wr_duty_3c", 16'h843C, 16, 1'b1, 40'h3C_33_A5_01_FF);
        frame("rd_duty",    16'h0400, 16, 1'b0, 40'h3C_33_A5_01_FF);
`ifdef SPI_READBACK_EN
        check_readback("rb_duty", 8'h3C);
`endif
        frame("rd_pwm_lo",  16'h0200, 16, 1'b0, 40'h3C_33_A5_01_FF);
`ifdef SPI_READBACK_EN
        check_readback("rb_pwm_lo", 8'hA5);
`endif
        frame("rd_addr5",   16'h0500, 16, 1'b0, 40'h3C_33_A5_01_FF);
`ifdef SPI_READBACK_EN
        check_readback("rb_addr5", 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_pwm_reg_if.md
Name: spi_pwm_reg_if

Overview:
- SPI peripheral (mode 0, write-oriented) that sits directly upstream of the PWM peripheral.
- Receives 16-bit frames from an external controller through the dedicated inputs, decodes them, and drives the register bank that configures output enables, PWM enables and PWM duty cycle.
- All SPI pins are asynchronous to clk. They are oversampled and edge-detected in the clk domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on sclk, copi and ncs (legal range 2..3).
- MAX_ADDR, 4, highest writable register address; frames addressed above this are discarded.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- sclk  input  1  SPI clock, asynchronous; frequency ≤ clk/8.
- copi  input  1  SPI controller-out data, MSB first.
- ncs  input  1  SPI chip select, active low.
- cipo  output  1  SPI controller-in data (readback only; see Optional Feature).
- cipo_oe  output  1  output enable for cipo.
- en_reg_out_7_0  output  8  register 0x00.
- en_reg_out_15_8  output  8  register 0x01.
- en_reg_pwm_7_0  output  8  register 0x02.
- en_reg_pwm_15_8  output  8  register 0x03.
- pwm_duty_cycle  output  8  register 0x04.
- frame_done  output  1  one-clk pulse when a valid write commits.

Behaviour:
- Reset: synchronous on clk when rst_n=0, and applies mid-frame as well.
  - All five registers, frame_done, cipo and cipo_oe go to 0.
  - Synchroniser flops go to idle values: sclk=0, ncs=1.
  - Shift register and bit counter are cleared; FSM enters IDLE.
  - Any partial frame is discarded.
- Synchronisation and edge detection:
  - Each pin passes through SYNC_STAGES flops plus one history flop.
  - sclk_rise = synced 1 and previous 0.
  - ncs_fall and ncs_rise are derived the same way.
- Frame format, MSB first:
  - bit15: R/W (1=write).
  - bits14:8: address.
  - bits7:0: data.
- FSM states:
  - IDLE: wait for ncs_fall → SHIFT. Count=0, overflow=0. If synced ncs is already low when reset releases, stay in IDLE until ncs has been seen high.
  - SHIFT: on each sclk_rise, shift synced copi into the LSB and increment a 5-bit count. When count reaches 16 → FULL. On ncs_rise with count<16 → IDLE, frame discarded.
  - FULL: any further sclk_rise sets overflow (count saturates at 16). On ncs_rise → COMMIT.
  - COMMIT: one cycle. If overflow=0, R/W=1 and addr ≤ MAX_ADDR, write data to the addressed register and pulse frame_done. Otherwise no state change and no pulse. Always → IDLE.
- Timing and edge cases:
  - Latency: a register write is visible ≤ SYNC_STAGES+3 clk cycles after the raw ncs rising edge.
  - If ncs_rise and sclk_rise occur in the same clk cycle, ncs_rise wins and that sclk edge is not sampled.
  - Write data is applied whole. Registers never show partial values and keep their value between frames.
  - frame_done is high for exactly one cycle per committed write.
- Read frames (R/W=0) without the optional feature: fully shifted, then discarded. cipo=0, cipo_oe=0 at all times.

Optional Feature:
- Macro: SPI_READBACK_EN.
- With the macro defined:
  - For a read frame with addr ≤ MAX_ADDR, the addressed register is captured into a tx shift register when count reaches 8.
  - cipo_oe=1 from that capture until ncs_rise.
  - cipo presents tx bit7 first, then updates on each synced sclk falling edge (MSB first, 8 bits).
  - For a read frame with addr > MAX_ADDR, cipo shifts out 0x00.
  - Registers are unchanged by reads and frame_done does not pulse.
- Without the macro: cipo and cipo_oe are constant 0, and no tx logic is synthesised.

Test Plan:
- Reset → all five registers read 0x00, frame_done=0, cipo_oe=0. Write 0x80F0 → en_reg_out_7_0=0xF0, exactly one frame_done pulse.
- Write 0x8455 then 0x8480 → pwm_duty_cycle=0x55 after the first frame and 0x80 after the second; registers 0x00–0x03 unchanged.
- Frame 0x8512 (addr 5) and frame 0x00AA (read, macro off) → no register changes, no frame_done.
- Truncated frame: 12 bits of 0x81FF then ncs high → en_reg_out_15_8 stays 0x00. Overflow frame: 17 bits starting 0x82C3 → en_reg_pwm_7_0 unchanged.
- rst_n=0 for 2 cycles after 9 bits of 0x8333, then release with ncs still low and finish the frame → register 0x03 stays 0x00. A following clean 0x8333 → 0x33.
- SPI_READBACK_EN defined: write 0x843C, then read 0x0400 → cipo returns 0x3C MSB first on the final 8 sclk edges, with cipo_oe high only during the data phase.
